// File: rtl/conv_sweep_scheduler_if.sv
// Job-descriptor channel into the convolution sweep scheduler.
// The master offers a descriptor and the scheduler takes it on valid && ready.
interface conv_sweep_cfg_if #(
    parameter int B_SHAPE = 32,
    parameter int B_PASS  = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_stride;
    logic [1:0]         cfg_pad;
    logic [B_SHAPE-1:0] cfg_wei_shape;
    logic [B_SHAPE-1:0] cfg_ftm_shape;
    logic [B_PASS-1:0]  cfg_n_pass;

    modport master (
        output cfg_valid, cfg_stride, cfg_pad, cfg_wei_shape, cfg_ftm_shape, cfg_n_pass,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_stride, cfg_pad, cfg_wei_shape, cfg_ftm_shape, cfg_n_pass,
        output cfg_ready
    );
endinterface

// File: rtl/conv_sweep_scheduler.sv
// Accepts a conv job descriptor, validates it, starts the reader and counts sweeps
// (one rdr_tog transition per sweep) before draining the datapath and pulsing done.
module conv_sweep_scheduler #(
    parameter int B_SHAPE     = 32,
    parameter int N_CONV_UNIT = 8,
    parameter int B_PASS      = 8,
    parameter int DRAIN_CYC   = 4
) (
    input  logic               clk,
    input  logic               rstn,
    conv_sweep_cfg_if.slave    cfg,
    input  logic               abort,
    output logic               rdr_rstn,
    output logic               rdr_start,
    output logic [1:0]         rdr_stride,
    output logic [1:0]         rdr_pad,
    output logic [B_SHAPE-1:0] rdr_wei_shape,
    output logic [B_SHAPE-1:0] rdr_ftm_shape,
    input  logic               rdr_tog,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [B_PASS-1:0]  pass_cnt
);

    localparam int CW_SH = $clog2(4 * N_CONV_UNIT);

    typedef enum logic [2:0] {
        IDLE, CHECK, START, RUN, DRAIN, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         stride_q, stride_d;
    logic [1:0]         pad_q, pad_d;
    logic [B_SHAPE-1:0] wei_q, wei_d;
    logic [B_SHAPE-1:0] ftm_q, ftm_d;
    logic [B_PASS-1:0]  n_pass_q, n_pass_d;
    logic [B_PASS-1:0]  pass_cnt_q, pass_cnt_d;
    logic               err_q, err_d;
    logic               tog_prev_q, tog_prev_d;
    logic [7:0]         drain_cnt_q, drain_cnt_d;

    // Shape fields widened to 12 bits so h/w + 2*pad cannot overflow.
    logic [11:0] c_wei, h_wei, w_wei, h_lim, w_lim;
    logic        cfg_bad;
    logic [B_PASS-1:0] pass_inc;

    always_comb begin
        c_wei   = wei_q[31:20];
        h_wei   = {2'b00, wei_q[19:10]};
        w_wei   = {2'b00, wei_q[9:0]};
        h_lim   = {2'b00, ftm_q[19:10]} + {9'd0, pad_q, 1'b0};
        w_lim   = {2'b00, ftm_q[9:0]}   + {9'd0, pad_q, 1'b0};
        cfg_bad = (stride_q == 2'd0) || (n_pass_q == '0) ||
                  (h_wei == 12'd0) || (w_wei == 12'd0) ||
                  ((c_wei >> CW_SH) == 12'd0) ||
                  (h_wei > h_lim) || (w_wei > w_lim);
        pass_inc = (pass_cnt_q == '1) ? pass_cnt_q : pass_cnt_q + B_PASS'(1);
    end

    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        pad_d       = pad_q;
        wei_d       = wei_q;
        ftm_d       = ftm_q;
        n_pass_d    = n_pass_q;
        pass_cnt_d  = pass_cnt_q;
        err_d       = err_q;
        tog_prev_d  = tog_prev_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    stride_d   = cfg.cfg_stride;
                    pad_d      = cfg.cfg_pad;
                    wei_d      = cfg.cfg_wei_shape;
                    ftm_d      = cfg.cfg_ftm_shape;
                    n_pass_d   = cfg.cfg_n_pass;
                    pass_cnt_d = '0;
                    err_d      = 1'b0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cfg_bad) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = START;
                end
            end
            START: begin
                tog_prev_d = 1'b0;
                state_d    = abort ? IDLE : RUN;
            end
            RUN: begin
                // Abort outranks a sweep edge in the same cycle, count included.
                if (abort) begin
                    state_d = IDLE;
                end else if (rdr_tog != tog_prev_q) begin
                    tog_prev_d = rdr_tog;
                    pass_cnt_d = pass_inc;
                    if (pass_inc == n_pass_q) begin
                        drain_cnt_d = 8'd0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (drain_cnt_q == 8'(DRAIN_CYC - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            stride_q    <= '0;
            pad_q       <= '0;
            wei_q       <= '0;
            ftm_q       <= '0;
            n_pass_q    <= '0;
            pass_cnt_q  <= '0;
            err_q       <= 1'b0;
            tog_prev_q  <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            pad_q       <= pad_d;
            wei_q       <= wei_d;
            ftm_q       <= ftm_d;
            n_pass_q    <= n_pass_d;
            pass_cnt_q  <= pass_cnt_d;
            err_q       <= err_d;
            tog_prev_q  <= tog_prev_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign rdr_rstn      = rstn && ((state_q == START) || (state_q == RUN) || (state_q == DRAIN));
    assign rdr_start     = (state_q == START);
    assign rdr_stride    = stride_q;
    assign rdr_pad       = pad_q;
    assign rdr_wei_shape = wei_q;
    assign rdr_ftm_shape = ftm_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign pass_cnt      = pass_cnt_q;

endmodule

// File: tb/tb_conv_sweep_scheduler.sv
// Directed bench for conv_sweep_scheduler; cycle k spans posedge k to posedge k+1,
// with a descriptor handshake taking place in cycle 0.
module tb_conv_sweep_scheduler;

    localparam int B_SHAPE = 32;
    localparam int B_PASS  = 8;

    logic clk = 1'b0;
    logic rstn;
    logic abort;
    logic rdr_rstn, rdr_start, rdr_tog, busy, done, err;
    logic [1:0] rdr_stride, rdr_pad;
    logic [B_SHAPE-1:0] rdr_wei_shape, rdr_ftm_shape;
    logic [B_PASS-1:0] pass_cnt;

    int cyc;
    int n_run  = 0;
    int n_fail = 0;
    int done_seen = 0;
    int last_done_cyc = -1;
    int base;
    int start_seen;

    conv_sweep_cfg_if #(.B_SHAPE(B_SHAPE), .B_PASS(B_PASS)) cif ();

    conv_sweep_scheduler #(
        .B_SHAPE(B_SHAPE), .N_CONV_UNIT(8), .B_PASS(B_PASS), .DRAIN_CYC(4)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg(cif), .abort(abort),
        .rdr_rstn(rdr_rstn), .rdr_start(rdr_start),
        .rdr_stride(rdr_stride), .rdr_pad(rdr_pad),
        .rdr_wei_shape(rdr_wei_shape), .rdr_ftm_shape(rdr_ftm_shape),
        .rdr_tog(rdr_tog), .busy(busy), .done(done), .err(err), .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_seen++;
            last_done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] shp(input int c, input int h, input int w);
        return {12'(c), 10'(h), 10'(w)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Presents a descriptor in cycle 0, returns in cycle 1 with valid dropped.
    task automatic start_job(input logic [1:0] st, input logic [1:0] pd,
                             input logic [31:0] wei, input logic [31:0] ftm,
                             input logic [7:0] np);
        cif.cfg_stride    = st;
        cif.cfg_pad       = pd;
        cif.cfg_wei_shape = wei;
        cif.cfg_ftm_shape = ftm;
        cif.cfg_n_pass    = np;
        cif.cfg_valid     = 1'b1;
        cyc = 0;
        tick();
        cif.cfg_valid = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; abort = 1'b0; rdr_tog = 1'b0;
        cif.cfg_valid = 1'b0; cif.cfg_stride = '0; cif.cfg_pad = '0;
        cif.cfg_wei_shape = '0; cif.cfg_ftm_shape = '0; cif.cfg_n_pass = '0;
        cyc = 0;
        tick(); tick();

        // Reset state
        chk("rst_ready", cif.cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_rrstn", rdr_rstn, 0);
        chk("rst_start", rdr_start, 0);
        chk("rst_wei", rdr_wei_shape, 0);
        rstn = 1'b1;
        tick();

        // Normal two-pass run
        base = done_seen;
        start_job(2'd1, 2'd1, shp(64, 3, 3), shp(64, 8, 8), 8'd2);
        chk("n_busy1", busy, 1);
        chk("n_ready1", cif.cfg_ready, 0);
        tick();
        chk("n_start2", rdr_start, 1);
        chk("n_rrstn2", rdr_rstn, 1);
        chk("n_wei", rdr_wei_shape, shp(64, 3, 3));
        chk("n_ftm", rdr_ftm_shape, shp(64, 8, 8));
        chk("n_stride", rdr_stride, 1);
        while (cyc < 50) begin
            if (cyc == 20) rdr_tog = 1'b1;
            if (cyc == 40) rdr_tog = 1'b0;
            tick();
            if (cyc == 3)  chk("n_start3", rdr_start, 0);
            if (cyc == 20) chk("n_pass0", pass_cnt, 0);
            if (cyc == 21) chk("n_pass1", pass_cnt, 1);
            if (cyc == 41) chk("n_pass2", pass_cnt, 2);
            if (cyc == 46) chk("n_busy46", busy, 0);
        end
        chk("n_done_cyc", last_done_cyc, 45);
        chk("n_done_cnt", done_seen - base, 1);
        chk("n_err", err, 0);

        // Channel count below the wrap divisor
        base = done_seen;
        start_seen = 0;
        start_job(2'd1, 2'd1, shp(16, 3, 3), shp(64, 8, 8), 8'd2);
        chk("b_rrstn1", rdr_rstn, 0);
        start_seen += int'(rdr_start);
        tick();
        chk("b_done2", done, 1);
        chk("b_err2", err, 1);
        chk("b_rrstn2", rdr_rstn, 0);
        start_seen += int'(rdr_start);
        tick();
        start_seen += int'(rdr_start);
        chk("b_start_never", start_seen, 0);
        chk("b_done3", done, 0);
        chk("b_busy3", busy, 0);
        tick(); tick();
        chk("b_err_hold", err, 1);

        // Kernel taller than padded feature map
        start_job(2'd1, 2'd1, shp(64, 11, 3), shp(64, 8, 8), 8'd1);
        chk("o_err_clr", err, 0);
        tick();
        chk("o_done2", done, 1);
        chk("o_err2", err, 1);
        tick();

        // Kernel exactly as tall as padded feature map is legal
        base = done_seen;
        start_job(2'd1, 2'd1, shp(64, 10, 3), shp(64, 8, 8), 8'd1);
        tick();
        chk("e_start2", rdr_start, 1);
        chk("e_err2", err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("e_abort_busy", busy, 0);
        tick(); tick();
        chk("e_no_done", done_seen - base, 0);

        // Abort in RUN after one of three passes
        base = done_seen;
        start_job(2'd1, 2'd0, shp(32, 3, 3), shp(32, 8, 8), 8'd3);
        while (cyc < 16) begin
            if (cyc == 10) rdr_tog = 1'b1;
            if (cyc == 15) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        chk("a_busy", busy, 0);
        chk("a_ready", cif.cfg_ready, 1);
        chk("a_pass", pass_cnt, 1);
        chk("a_err", err, 0);
        tick(); tick(); tick();
        chk("a_no_done", done_seen - base, 0);
        chk("a_pass_hold", pass_cnt, 1);
        rdr_tog = 1'b0;
        tick();

        // Final edge and abort in the same cycle
        base = done_seen;
        start_job(2'd1, 2'd0, shp(32, 3, 3), shp(32, 8, 8), 8'd1);
        while (cyc < 11) begin
            if (cyc == 10) begin rdr_tog = 1'b1; abort = 1'b1; end
            tick();
        end
        abort = 1'b0;
        chk("s_busy", busy, 0);
        chk("s_pass", pass_cnt, 0);
        repeat (8) tick();
        chk("s_no_done", done_seen - base, 0);
        rdr_tog = 1'b0;
        tick();

        // Reset during DRAIN
        base = done_seen;
        start_job(2'd1, 2'd0, shp(32, 3, 3), shp(32, 8, 8), 8'd1);
        while (cyc < 12) begin
            if (cyc == 10) rdr_tog = 1'b1;
            tick();
        end
        chk("r_drain_busy", busy, 1);
        chk("r_drain_pass", pass_cnt, 1);
        rstn = 1'b0;
        tick();
        chk("r_busy", busy, 0);
        chk("r_ready", cif.cfg_ready, 1);
        chk("r_rrstn", rdr_rstn, 0);
        chk("r_pass", pass_cnt, 0);
        chk("r_wei", rdr_wei_shape, 0);
        chk("r_done", done, 0);
        rstn = 1'b1;
        rdr_tog = 1'b0;
        repeat (8) tick();
        chk("r_no_done", done_seen - base, 0);

        // Backpressure: second descriptor held while the first job runs
        base = done_seen;
        cif.cfg_stride = 2'd1; cif.cfg_pad = 2'd1;
        cif.cfg_wei_shape = shp(64, 3, 3); cif.cfg_ftm_shape = shp(64, 8, 8);
        cif.cfg_n_pass = 8'd1;
        cif.cfg_valid = 1'b1;
        cyc = 0;
        tick();
        cif.cfg_wei_shape = shp(64, 5, 5);
        chk("p_ready1", cif.cfg_ready, 0);
        chk("p_weiA1", rdr_wei_shape, shp(64, 3, 3));
        while (cyc < 12) begin
            if (cyc == 5) rdr_tog = 1'b1;
            tick();
            if (cyc == 8)  chk("p_weiA8", rdr_wei_shape, shp(64, 3, 3));
            if (cyc == 10) chk("p_done10", done, 1);
            if (cyc == 11) chk("p_ready11", cif.cfg_ready, 1);
        end
        cif.cfg_valid = 1'b0;
        chk("p_weiB", rdr_wei_shape, shp(64, 5, 5));
        chk("p_busyB", busy, 1);
        while (cyc < 24) tick();
        chk("p_doneB_cyc", last_done_cyc, 19);
        chk("p_done_cnt", done_seen - base, 2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_sweep_scheduler.md
CONV_SWEEP_SCHEDULER -- requirements
Module: conv_sweep_scheduler

Interface
REQ-001 SHALL have parameter B_SHAPE, default 32, width of packed shape words.
REQ-002 SHALL have parameter N_CONV_UNIT, default 8, conv units per channel wrap; channel-wrap divisor is 4*N_CONV_UNIT.
REQ-003 SHALL have parameter B_PASS, default 8, width of pass count.
REQ-004 SHALL have parameter DRAIN_CYC, default 4, cycles waited after the last sweep for the datapath to drain; legal range is 1..255.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  scheduler accepts a descriptor.
- cfg_stride  in  2  stride.
- cfg_pad  in  2  pad.
- cfg_wei_shape  in  B_SHAPE  {c[31:20], h[19:10], w[9:0]}.
- cfg_ftm_shape  in  B_SHAPE  same packing.
- cfg_n_pass  in  B_PASS  sweeps to run.
- abort  in  1  cancel the current job.
- rdr_rstn  out  1  reader reset, active-low.
- rdr_start  out  1  reader start pulse.
- rdr_stride / rdr_pad  out  2 each  latched config.
- rdr_wei_shape / rdr_ftm_shape  out  B_SHAPE each  latched config.
- rdr_tog  in  1  reader toggles once per complete sweep.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-end pulse.
- err  out  1  config rejected.
- pass_cnt  out  B_PASS  sweeps completed.

Function
REQ-006 SHALL implement states IDLE, CHECK, START, RUN, DRAIN, DONE.
REQ-007 SHALL drive cfg_ready=1 only in IDLE; the handshake is cfg_valid&&cfg_ready.
REQ-008 SHALL, on handshake:
- latch all cfg_* fields into rdr_* and the internal n_pass register;
- clear pass_cnt and err;
- enter CHECK.
REQ-009 SHALL, in CHECK, set err=1 and go to DONE if any of the following holds; otherwise go to START:
- stride==0;
- n_pass==0;
- h_wei==0 or w_wei==0;
- (c_wei >> log2(4*N_CONV_UNIT))==0;
- h_wei > h_ftm+2*pad;
- w_wei > w_ftm+2*pad.
REQ-010 SHALL evaluate the CHECK comparisons at 12 bits minimum, with no overflow.
REQ-011 SHALL drive rdr_rstn = rstn AND (state in START, RUN, DRAIN); the reader is held in reset in all other states.
REQ-012 SHALL, in START:
- assert rdr_start for exactly one cycle;
- clear tog_prev to 0;
- enter RUN.
REQ-013 SHALL detect a sweep edge in RUN when rdr_tog != tog_prev, then:
- set tog_prev<=rdr_tog;
- increment pass_cnt by 1.
REQ-014 SHALL enter DRAIN in the cycle after an edge that makes pass_cnt equal n_pass.
REQ-015 SHALL ignore any rdr_tog change outside RUN.
REQ-016 SHALL remain in DRAIN exactly DRAIN_CYC cycles, then enter DONE.
REQ-017 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-018 SHALL hold err stable from DONE until the next handshake.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL, on abort=1 in CHECK, START, RUN or DRAIN:
- go to IDLE next cycle;
- not pulse done;
- not set err;
- leave pass_cnt holding its value.
REQ-021 SHALL ignore abort in IDLE and in DONE.
REQ-022 SHALL give abort priority over a simultaneous final sweep edge.
REQ-023 SHALL, for a handshake at cycle 0, assert rdr_start at cycle 2 and be in RUN from cycle 3.
REQ-024 SHALL, for a final edge sampled at cycle T, assert done at cycle T+1+DRAIN_CYC.
REQ-025 SHALL saturate pass_cnt at its maximum value rather than wrap.

Reset
REQ-026 SHALL, while rstn=0 at a clock edge, force:
- state=IDLE;
- cfg_ready=1;
- rdr_start=0, rdr_rstn=0, busy=0, done=0, err=0;
- pass_cnt=0, tog_prev=0;
- all rdr_* config=0.
REQ-027 SHALL abandon any in-flight job on reset mid-operation, with no done pulse after release.

Verification
REQ-028 Normal run:
- stimulus: stride=1, pad=1, wei={c=64, h=3, w=3}, ftm={c=64, h=8, w=8}, n_pass=2; bench toggles rdr_tog at cycles 20 and 40;
- required: rdr_start at cycle 2; pass_cnt 1 then 2; done at cycle 45; busy low at cycle 46; err=0.
REQ-029 Bad config:
- stimulus: c_wei=16 (wrap divisor 32);
- required: done at cycle 2 with err=1; rdr_start never asserted; rdr_rstn stays 0.
REQ-030 Oversized kernel:
- stimulus: wei h=11, ftm h=8, pad=1;
- required: err=1; done at cycle 2.
REQ-031 Abort:
- stimulus: abort during RUN after 1 of 3 passes;
- required: IDLE next cycle; done never asserted; pass_cnt=1; cfg_ready=1.
REQ-032 Simultaneous events:
- stimulus: final rdr_tog edge and abort in the same cycle;
- required: abort wins; no done pulse.
REQ-033 Reset and backpressure:
- stimulus: rstn=0 during DRAIN, then a second cfg_valid held high while busy;
- required: all outputs at reset values; the second descriptor is accepted only once back in IDLE.
